rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Four-requester round-robin arbiter that shares one downstream resource (e.g. an encoder/datapath slot) between requesters. It registers a one-hot grant plus its binary index, holds the grant until the owner signals completion, drops its request, or exceeds a hold limit, then rotates priority past the last owner. It sits between the requesting units and the shared resource, and drives the resource's select/enable.

## Interface

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles a grant may be held; legal range 2..15.
- HOLD_W, default 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- done  input  1  the current owner has finished; sampled only in GRANT.
- gnt  output  4  registered one-hot grant; all zeros when nothing is granted.
- gnt_id  output  2  binary index of the granted requester; 0 when idle.
- busy  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse; the previous grant was revoked by the hold limit.

## Operation

- Reset (rst=0 at a clock edge) sets: state=IDLE, gnt=0000, gnt_id=0, busy=0, timeout=0, ptr=0, cnt=0. Reset overrides every other input, including in the middle of a grant.
- State IDLE:
  - If req is 0000, stay in IDLE.
  - Otherwise, search cyclically upward from index ptr (ptr, ptr+1, … mod 4). The first set bit wins.
  - Register the winner: gnt=onehot(winner), gnt_id=winner, busy=1, cnt=0, state=GRANT.
  - done is ignored in IDLE.
- State GRANT: release occurs at the first edge where any of these holds:
  - done=1;
  - req[gnt_id]=0 (the requester withdrew);
  - cnt==MAX_HOLD-1 (hold limit reached).
- If no release condition holds, increment cnt.
- On release:
  - gnt=0000, gnt_id=0, busy=0, state=IDLE.
  - ptr=(gnt_id+1) mod 4, so 3 wraps to 0.
  - timeout=1 only if the release was caused solely by the hold limit, i.e. done=0 and req[gnt_id]=1.
- Precedence: done or withdrawal wins over the hold limit in the same cycle, and then timeout stays 0.
- timeout is high for exactly one cycle, the first IDLE cycle after the revoke. In every other cycle it is 0.
- A requester that timed out keeps its request eligible. Because ptr has moved past it, it is re-served only after the other active requesters.
- gnt never has more than one bit set. gnt_id is always consistent with gnt.

## Timing

- Grant latency: a request sampled in IDLE at edge k appears on gnt after edge k (visible in cycle k+1).
- Handover gap: release at edge k gives gnt=0000 during cycle k+1. The next grant appears after edge k+1. There is always exactly one dead cycle between owners.
- Maximum hold: a grant is visible for at most MAX_HOLD consecutive cycles.
- Worst-case wait for a requester that holds req continuously: 3×(MAX_HOLD+1) cycles after its request is first sampled in IDLE.
- All outputs are registered. There is no combinational path from req/done to any output.

## Test plan

- Reset: hold rst=0 for 2 cycles with req=1111. Required: gnt=0000, gnt_id=0, busy=0, timeout=0. After rst goes to 1: gnt=0001 and gnt_id=0 one edge later.
- Rotation: req=1111 held, done=1 in every GRANT cycle. Required gnt sequence per cycle: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (wrap 3→0).
- Hold limit (MAX_HOLD=8): req=0011, done=0. Required:
  - gnt=0001 for exactly 8 cycles;
  - then gnt=0000 with timeout=1 for one cycle;
  - then gnt=0010, gnt_id=1.
- Withdraw and precedence:
  - Owner 2 drops req[2] in grant cycle 3: gnt=0000 on the next cycle, timeout=0.
  - Separately, done=1 on cycle 8 of a grant: timeout=0.
- Single requester with wrap: req=0100 only. Required:
  - grant 0100, gnt_id=2;
  - after done: one idle cycle, then regrant 0100 (search starting from ptr=3 wraps around to 2).
- Reset mid-grant: while gnt=0100, set rst=0 for one edge. Required:
  - all outputs zero the following cycle;
  - with rst=1 and req=0101: next grant is 0001 (ptr restored to 0).

Source files
------------

// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant, hold limit and
// a one-cycle timeout pulse when a grant is revoked by the hold limit.
module rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [3:0]        gnt_q;
  logic [1:0]        gnt_id_q;
  logic              busy_q;
  logic              timeout_q;
  logic [1:0]        ptr_q;
  logic [HOLD_W-1:0] cnt_q;

  logic [1:0] win_idx;
  logic       win_found;
  logic       owner_req;
  logic       hold_limit;
  logic       release_now;

  // Cyclic search upward from ptr_q; the first set request wins.
  always_comb begin
    win_idx   = 2'd0;
    win_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        win_idx   = ptr_q + 2'(i);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_req   = req[gnt_id_q];
    hold_limit  = (cnt_q == HOLD_W'(MAX_HOLD - 1));
    release_now = done || !owner_req || hold_limit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timeout_q <= 1'b0;
          if (win_found) begin
            gnt_q    <= 4'b0001 << win_idx;
            gnt_id_q <= win_idx;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          if (release_now) begin
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            busy_q    <= 1'b0;
            ptr_q     <= gnt_id_q + 2'd1;
            // Only a revoke caused purely by the hold limit is reported.
            timeout_q <= !done && owner_req;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: a vector table for reset and rotation, then
// hand-written sequences for hold limit, withdrawal, precedence, wrap and mid-grant reset.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter #(
    .MAX_HOLD(8),
    .HOLD_W  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_v;
    logic [3:0] req_v;
    logic       done_v;
    logic [3:0] gnt_e;
    logic [1:0] id_e;
    logic       busy_e;
    logic       to_e;
  } vec_t;

  vec_t vecs[12];

  // Drive inputs, let one rising edge pass, then settle before sampling.
  task automatic apply(input logic r, input logic [3:0] rq, input logic d);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] eg, input logic [1:0] eid,
                            input logic eb, input logic et);
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== {eg, eid, eb, et}) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, want gnt=%b id=%0d busy=%b timeout=%b",
               name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
    end
  endtask

  initial begin
    rst  = 1'b0;
    req  = 4'b1111;
    done = 1'b0;

    //          rst   req      done  gnt      id    busy  to
    vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rst_v, vecs[i].req_v, vecs[i].done_v);
      expect_out($sformatf("vec%0d", i), vecs[i].gnt_e, vecs[i].id_e, vecs[i].busy_e,
                 vecs[i].to_e);
    end

    // Hold limit: reset to bring ptr back to 0, then two requesters with done low.
    apply(1'b0, 4'b0011, 1'b0);
    expect_out("hold_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 4'b0011, 1'b0);
    expect_out("hold_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      apply(1'b1, 4'b0011, 1'b0);
      expect_out($sformatf("hold_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    apply(1'b1, 4'b0011, 1'b0);
    expect_out("hold_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    apply(1'b1, 4'b0011, 1'b0);
    expect_out("hold_next", 4'b0010, 2'd1, 1'b1, 1'b0);
    apply(1'b1, 4'b0011, 1'b1);
    expect_out("hold_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Withdrawal: ptr=2, owner 2 drops its request in grant cycle 3.
    apply(1'b1, 4'b0100, 1'b0);
    expect_out("wd_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    expect_out("wd_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    expect_out("wd_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    apply(1'b1, 4'b0000, 1'b0);
    expect_out("wd_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Precedence: done in grant cycle 8 coincides with the hold limit, no timeout.
    apply(1'b1, 4'b0010, 1'b0);
    expect_out("prec_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      apply(1'b1, 4'b0010, 1'b0);
      expect_out($sformatf("prec_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    apply(1'b1, 4'b0010, 1'b1);
    expect_out("prec_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 4'b0000, 1'b0);
    expect_out("prec_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2: after done, ptr=3 and the search wraps back to 2.
    apply(1'b1, 4'b0100, 1'b0);
    expect_out("wrap_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    apply(1'b1, 4'b0100, 1'b1);
    expect_out("wrap_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 4'b0100, 1'b0);
    expect_out("wrap_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Reset in the middle of that grant restores ptr to 0.
    apply(1'b0, 4'b0100, 1'b0);
    expect_out("midrst_zero", 4'b0000, 2'd0, 1'b0, 1'b0);
    apply(1'b1, 4'b0101, 1'b0);
    expect_out("midrst_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
